inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/ifq_pkg.sv | 22 ++
 rtl/ifq_fifo.sv | 65 ++++++
 rtl/inst_fetch_queue.sv | 150 +++++++++++++++
 tb/tb_inst_fetch_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared types and constants for the instruction fetch queue
// Contents:
//   IFQ_DEPTH_DEFAULT : default number of queue entries / outstanding fetches
//   IFQ_PC_W          : PC width carried in an instruction FIFO entry (size must not exceed it)
//   ifq_state_t       : RUN (no stale responses pending) / DRAIN (discarding stale responses)
//   fetch_entry_t     : {pc, inst} pair held in the instruction FIFO
package ifq_pkg;

    localparam int IFQ_DEPTH_DEFAULT = 4;
    localparam int IFQ_PC_W          = 32;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ifq_state_t;

    typedef struct packed {
        logic [IFQ_PC_W-1:0] pc;
        logic [31:0]         inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - parameterised synchronous FIFO with synchronous clear
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   clear          : empties the FIFO on the next edge (overrides push/pop)
//   push/push_data : write an entry (ignored when full unless popping too)
//   pop/pop_data   : remove the head entry; pop_data shows the head combinationally
//   count, empty   : occupancy, $clog2(DEPTH)+1 bits
module ifq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - credit-based instruction fetch queue with flush/drain
// Ports:
//   clk, reset                                 : clock, asynchronous active-low reset
//   pc_addr, pc_valid, pc_ready                : fetch addresses from the PC stage
//   flush                                      : redirect; drops queued and in-flight fetches
//   mem_req_addr, mem_req_valid, mem_req_ready : instruction memory request channel
//   mem_rsp_data, mem_rsp_valid                : in-order memory responses
//   inst_out, inst_pc, inst_valid, inst_ready  : instruction stream to decode
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int size  = 32,
    parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [size-1:0] pc_addr,
    input  logic            pc_valid,
    output logic            pc_ready,
    input  logic            flush,
    output logic [size-1:0] mem_req_addr,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    input  logic [31:0]     mem_rsp_data,
    input  logic            mem_rsp_valid,
    output logic [31:0]     inst_out,
    output logic [size-1:0] inst_pc,
    output logic            inst_valid,
    input  logic            inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = $bits(fetch_entry_t);

    ifq_state_t   state;
    ifq_state_t   state_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_next;
    logic [CW-1:0] stale_total;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_sum;
    logic          credit;
    logic          fire;
    logic          rsp_keep;
    logic          inst_pop;
    logic          af_empty;
    logic          if_empty;
    logic [size-1:0] af_head;
    logic [EW-1:0]   if_head;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // Every fetch that may still return a word reserves a FIFO slot, so an
    // accepted response can always be written without a full check.
    assign credit_sum = {1'b0, outstanding} + {1'b0, drop_cnt} + {1'b0, fifo_count};
    assign credit     = credit_sum < (CW+1)'(DEPTH);

    assign mem_req_addr  = pc_addr;
    assign mem_req_valid = pc_valid & credit & ~flush;
    assign pc_ready      = mem_req_ready & credit & ~flush;
    assign fire          = mem_req_valid & mem_req_ready;

    // Responses with nothing tracked (e.g. after a reset) fall through unused.
    assign rsp_keep = mem_rsp_valid & (state == RUN) & ~af_empty & ~flush;
    assign inst_pop = inst_ready & inst_valid & ~flush;

    // The in-flight queue count is the outstanding-request counter.
    ifq_fifo #(
        .WIDTH (size),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (fire),
        .push_data (pc_addr),
        .pop       (rsp_keep),
        .pop_data  (af_head),
        .count     (outstanding),
        .empty     (af_empty)
    );

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = IFQ_PC_W'(af_head);
        push_entry.inst = mem_rsp_data;
    end

    ifq_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (inst_pop),
        .pop_data  (if_head),
        .count     (fifo_count),
        .empty     (if_empty)
    );

    assign head_entry = fetch_entry_t'(if_head);
    assign inst_valid = ~if_empty;
    assign inst_out   = inst_valid ? head_entry.inst : '0;
    assign inst_pc    = inst_valid ? size'(head_entry.pc) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            drop_cnt <= drop_next;
        end
    end

    always_comb begin
        state_next  = state;
        drop_next   = drop_cnt;
        stale_total = drop_cnt + outstanding;
        if (flush) begin
            // Everything still owed by memory becomes stale; a response landing
            // in the flush cycle itself is already one of them.
            if (mem_rsp_valid && stale_total != '0) begin
                stale_total = stale_total - CW'(1);
            end
            drop_next  = stale_total;
            state_next = (stale_total != '0) ? DRAIN : RUN;
        end else begin
            case (state)
                RUN: begin
                    drop_next  = '0;
                    state_next = RUN;
                end
                DRAIN: begin
                    if (mem_rsp_valid) drop_next = drop_cnt - CW'(1);
                    state_next = (drop_next == '0) ? RUN : DRAIN;
                end
                default: begin
                    drop_next  = '0;
                    state_next = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;
    import ifq_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic [31:0] mem_req_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    int tests;
    int failed;

    inst_fetch_queue #(.size(32), .DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_addr       (pc_addr),
        .pc_valid      (pc_valid),
        .pc_ready      (pc_ready),
        .flush         (flush),
        .mem_req_addr  (mem_req_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_valid (mem_rsp_valid),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic rsp(input logic [31:0] pc);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = word_of(pc);
    endtask

    task automatic no_rsp();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    task automatic req(input logic [31:0] pc);
        pc_valid = 1'b1;
        pc_addr  = pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        failed = 0;
        reset = 1'b0;
        pc_addr = '0;
        pc_valid = 1'b0;
        flush = 1'b0;
        mem_req_ready = 1'b1;
        mem_rsp_data = '0;
        mem_rsp_valid = 1'b0;
        inst_ready = 1'b0;

        // Reset state
        #12;
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_out", inst_out, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_fifo_count", dut.fifo_count, 0);
        check("rst_outstanding", dut.outstanding, 0);
        check("rst_drop_cnt", dut.drop_cnt, 0);
        check("rst_state", dut.state, RUN);
        mid();
        reset = 1'b1;

        // Streaming PCs 0..3 with 1-cycle responses and decode always ready
        nxt(); req(0); mid();
        check("st_pc_ready", pc_ready, 1);
        check("st_req_valid", mem_req_valid, 1);
        check("st_req_addr", mem_req_addr, 0);
        nxt(); req(1); rsp(0); mid();
        check("st_no_early_valid", inst_valid, 0);
        nxt(); req(2); rsp(1); inst_ready = 1'b1; mid();
        check("st_pc0", inst_pc, 0);
        check("st_inst0", inst_out, word_of(0));
        nxt(); req(3); rsp(2); mid();
        check("st_pc1", inst_pc, 1);
        nxt(); pc_valid = 1'b0; rsp(3); mid();
        check("st_pc2", inst_pc, 2);
        nxt(); no_rsp(); mid();
        check("st_pc3", inst_pc, 3);
        check("st_inst3", inst_out, word_of(3));
        nxt(); inst_ready = 1'b0; mid();
        check("st_empty", inst_valid, 0);
        check("st_outstanding", dut.outstanding, 0);

        // Backpressure: decode stalled, credit runs out after four fetches
        for (int k = 0; k < 4; k++) begin
            nxt(); req(32'h10 + k);
            if (k > 0) rsp(32'h10 + k - 1);
            mid();
            check("bp_fire_ready", pc_ready, 1);
        end
        nxt(); req(32'h14); rsp(32'h13); mid();
        check("bp_no_credit", pc_ready, 0);
        nxt(); no_rsp(); mid();
        check("bp_fifo_full", dut.fifo_count, 4);
        check("bp_still_blocked", pc_ready, 0);
        check("bp_head", inst_pc, 32'h10);
        inst_ready = 1'b1;
        nxt(); inst_ready = 1'b0; mid();
        check("bp_after_pop", dut.fifo_count, 3);
        check("bp_one_fire", pc_ready, 1);
        nxt(); rsp(32'h14); mid();
        check("bp_blocked_again", pc_ready, 0);
        pc_valid = 1'b0;
        nxt(); no_rsp(); inst_ready = 1'b1; mid();
        check("bp_full_again", dut.fifo_count, 4);
        check("bp_order0", inst_pc, 32'h11);
        nxt(); mid();
        check("bp_order1", inst_pc, 32'h12);
        nxt(); mid();
        check("bp_order2", inst_pc, 32'h13);
        nxt(); mid();
        check("bp_order3", inst_pc, 32'h14);
        check("bp_order3_inst", inst_out, word_of(32'h14));
        nxt(); inst_ready = 1'b0; mid();
        check("bp_drained", inst_valid, 0);

        // Flush with two outstanding fetches, then redirect to 0x40
        nxt(); req(32'h20); mid();
        nxt(); req(32'h21); mid();
        check("fl_out1", dut.outstanding, 1);
        nxt(); req(32'h22); flush = 1'b1; mid();
        check("fl_req_blocked", mem_req_valid, 0);
        check("fl_ready_blocked", pc_ready, 0);
        check("fl_out2", dut.outstanding, 2);
        nxt(); flush = 1'b0; req(32'h40); rsp(32'h20); mid();
        check("fl_state", dut.state, DRAIN);
        check("fl_drop2", dut.drop_cnt, 2);
        check("fl_out0", dut.outstanding, 0);
        check("fl_ready_drain", pc_ready, 1);
        check("fl_valid0", inst_valid, 0);
        nxt(); pc_valid = 1'b0; rsp(32'h21); mid();
        check("fl_drop1", dut.drop_cnt, 1);
        check("fl_out_new", dut.outstanding, 1);
        check("fl_hidden0", inst_valid, 0);
        nxt(); rsp(32'h40); mid();
        check("fl_drop0", dut.drop_cnt, 0);
        check("fl_run", dut.state, RUN);
        check("fl_hidden1", inst_valid, 0);
        nxt(); no_rsp(); inst_ready = 1'b1; mid();
        check("fl_new_valid", inst_valid, 1);
        check("fl_new_pc", inst_pc, 32'h40);
        check("fl_new_inst", inst_out, word_of(32'h40));
        nxt(); inst_ready = 1'b0; mid();
        check("fl_new_popped", inst_valid, 0);

        // Flush coincident with a response and a request
        nxt(); req(32'h50); mid();
        nxt(); req(32'h51); rsp(32'h50); mid();
        nxt(); req(32'h52); no_rsp(); mid();
        nxt(); req(32'h53); mid();
        check("fc_credit", pc_ready, 1);
        nxt(); req(32'h54); flush = 1'b1; rsp(32'h51); inst_ready = 1'b1; mid();
        check("fc_req_blocked", mem_req_valid, 0);
        check("fc_ready_blocked", pc_ready, 0);
        check("fc_out3", dut.outstanding, 3);
        check("fc_valid_before", inst_valid, 1);
        nxt(); flush = 1'b0; pc_valid = 1'b0; no_rsp(); inst_ready = 1'b0; mid();
        check("fc_drop2", dut.drop_cnt, 2);
        check("fc_state", dut.state, DRAIN);
        check("fc_out0", dut.outstanding, 0);
        check("fc_fifo0", dut.fifo_count, 0);
        check("fc_valid_after", inst_valid, 0);
        nxt(); rsp(32'h52); mid();
        nxt(); rsp(32'h53); mid();
        check("fc_drop1", dut.drop_cnt, 1);
        nxt(); no_rsp(); mid();
        check("fc_drop0", dut.drop_cnt, 0);
        check("fc_run", dut.state, RUN);
        check("fc_nothing", inst_valid, 0);
        check("fc_fifo_end", dut.fifo_count, 0);

        // Asynchronous reset with data queued and three fetches in flight
        nxt(); req(32'h60); mid();
        nxt(); req(32'h61); rsp(32'h60); mid();
        nxt(); req(32'h62); no_rsp(); mid();
        nxt(); req(32'h63); mid();
        nxt(); pc_valid = 1'b0; mid();
        check("ar_valid_before", inst_valid, 1);
        check("ar_out3", dut.outstanding, 3);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid_async", inst_valid, 0);
        check("ar_inst_out", inst_out, 0);
        check("ar_fifo_async", dut.fifo_count, 0);
        nxt(); nxt(); mid();
        reset = 1'b1;
        check("ar_out0", dut.outstanding, 0);
        check("ar_drop0", dut.drop_cnt, 0);
        check("ar_state", dut.state, RUN);
        nxt(); rsp(32'h99); mid();
        nxt(); no_rsp(); mid();
        check("ar_stray_fifo", dut.fifo_count, 0);
        check("ar_stray_valid", inst_valid, 0);
        check("ar_stray_out", dut.outstanding, 0);

        // Simultaneous push and pop at fifo_count = 3
        nxt(); req(32'h70); mid();
        nxt(); req(32'h71); rsp(32'h70); mid();
        nxt(); req(32'h72); rsp(32'h71); mid();
        nxt(); req(32'h73); rsp(32'h72); mid();
        check("pp_credit", pc_ready, 1);
        nxt(); pc_valid = 1'b0; rsp(32'h73); inst_ready = 1'b1; mid();
        check("pp_count_before", dut.fifo_count, 3);
        check("pp_head0", inst_pc, 32'h70);
        nxt(); no_rsp(); mid();
        check("pp_count_same", dut.fifo_count, 3);
        check("pp_head1", inst_pc, 32'h71);
        nxt(); mid();
        check("pp_head2", inst_pc, 32'h72);
        nxt(); mid();
        check("pp_head3", inst_pc, 32'h73);
        check("pp_inst3", inst_out, word_of(32'h73));
        nxt(); inst_ready = 1'b0; mid();
        check("pp_empty", inst_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
